// File: rtl/if_id_queue.sv
// IF/ID pipeline stage with a DEPTH-entry instruction queue ahead of the decode slot.
// Hazard stalls fill the queue, memory stalls freeze everything, and a flush seen during a memory stall is deferred.
module if_id_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [INST_W-1:0] NOP_INST = 32'hFC000000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [ADDR_W-1:0]            inst_addr_i,
    input  logic [INST_W-1:0]            inst_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic                         hd_i,
    input  logic                         memstall_i,
    input  logic                         flush_i,
    output logic [INST_W-1:0]            inst_o,
    output logic [ADDR_W-1:0]            inst_addr_o,
    output logic                         valid_o,
    output logic [5:0]                   op_o,
    output logic [4:0]                   rs_o,
    output logic [4:0]                   rt_o,
    output logic [4:0]                   rd_o,
    output logic [15:0]                  imm_o,
    output logic [25:0]                  jaddr_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              flush_pend_q, flush_pend_d;
    logic              push, eff_flush, wr_en;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Derived from the registered count, so a same-cycle pop never reopens ready.
    assign ready_o   = !memstall_i && (count_q < CW'(DEPTH));
    assign push      = valid_i && ready_o;
    assign eff_flush = flush_i || flush_pend_q;

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        inst_d       = inst_q;
        addr_d       = addr_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        wr_en        = 1'b0;

        if (memstall_i) begin
            if (flush_i) flush_pend_d = 1'b1;
        end else if (eff_flush) begin
            // Any push this cycle is swallowed along with the queue contents.
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            inst_d       = NOP_INST;
            valid_d      = 1'b0;
            flush_pend_d = 1'b0;
        end else if (hd_i) begin
            if (push) begin
                wr_en   = 1'b1;
                tail_d  = next_ptr(tail_q);
                count_d = count_q + CW'(1);
            end
        end else if (count_q != '0) begin
            inst_d  = inst_mem_q[head_q];
            addr_d  = addr_mem_q[head_q];
            valid_d = 1'b1;
            head_d  = next_ptr(head_q);
            if (push) begin
                wr_en  = 1'b1;
                tail_d = next_ptr(tail_q);
            end else begin
                count_d = count_q - CW'(1);
            end
        end else if (push) begin
            inst_d  = inst_i;
            addr_d  = inst_addr_i;
            valid_d = 1'b1;
        end else begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            inst_q       <= NOP_INST;
            addr_q       <= '0;
            valid_q      <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            inst_q       <= inst_d;
            addr_q       <= addr_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Queue storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            inst_mem_q[tail_q] <= inst_i;
            addr_mem_q[tail_q] <= inst_addr_i;
        end
    end

    assign inst_o      = inst_q;
    assign inst_addr_o = addr_q;
    assign valid_o     = valid_q;
    assign count_o     = count_q;
    assign op_o        = inst_q[31:26];
    assign rs_o        = inst_q[25:21];
    assign rt_o        = inst_q[20:16];
    assign rd_o        = inst_q[15:11];
    assign imm_o       = inst_q[15:0];
    assign jaddr_o     = inst_q[25:0];

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios followed by random traffic,
// checked against a queue-based model of the stage.
module tb_if_id_queue;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'hFC000000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] inst_addr_i, inst_i, inst_o, inst_addr_o;
    logic        valid_i, ready_o, hd_i, memstall_i, flush_i, valid_o;
    logic [5:0]  op_o;
    logic [4:0]  rs_o, rt_o, rd_o;
    logic [15:0] imm_o;
    logic [25:0] jaddr_o;
    logic [1:0]  count_o;

    if_id_queue #(
        .ADDR_W   (32),
        .INST_W   (32),
        .DEPTH    (DEPTH),
        .NOP_INST (NOP)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inst_addr_i (inst_addr_i),
        .inst_i      (inst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .hd_i        (hd_i),
        .memstall_i  (memstall_i),
        .flush_i     (flush_i),
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o),
        .valid_o     (valid_o),
        .op_o        (op_o),
        .rs_o        (rs_o),
        .rt_o        (rt_o),
        .rd_o        (rd_o),
        .imm_o       (imm_o),
        .jaddr_o     (jaddr_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    int passed = 0;
    int total  = 0;

    // Reference model: decode slot plus a FIFO of {addr, inst} pairs.
    logic [31:0] m_inst, m_addr;
    logic        m_valid, m_pend, m_push;
    logic [63:0] mq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_inst  = NOP;
        m_addr  = 32'h0;
        m_valid = 1'b0;
        m_pend  = 1'b0;
        m_push  = 1'b0;
        mq.delete();
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, "_inst"},  64'(inst_o),      64'(m_inst));
        chk({tag, "_addr"},  64'(inst_addr_o), 64'(m_addr));
        chk({tag, "_valid"}, 64'(valid_o),     64'(m_valid));
        chk({tag, "_count"}, 64'(count_o),     64'(mq.size()));
        chk({tag, "_op"},    64'(op_o),        64'(m_inst[31:26]));
        chk({tag, "_rs"},    64'(rs_o),        64'(m_inst[25:21]));
        chk({tag, "_rt"},    64'(rt_o),        64'(m_inst[20:16]));
        chk({tag, "_rd"},    64'(rd_o),        64'(m_inst[15:11]));
        chk({tag, "_imm"},   64'(imm_o),       64'(m_inst[15:0]));
        chk({tag, "_jaddr"}, 64'(jaddr_o),     64'(m_inst[25:0]));
    endtask

    // One clock: drive inputs, check ready, step the model, check state after the edge.
    task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] i,
                       input logic hd, input logic ms, input logic fl);
        logic rdy;
        valid_i     = v;
        inst_addr_i = a;
        inst_i      = i;
        hd_i        = hd;
        memstall_i  = ms;
        flush_i     = fl;
        #1;
        rdy    = !ms && (mq.size() < DEPTH);
        m_push = v && rdy;
        chk("ready", 64'(ready_o), 64'(rdy));
        if (ms) begin
            if (fl) m_pend = 1'b1;
        end else if (fl || m_pend) begin
            mq.delete();
            m_inst  = NOP;
            m_valid = 1'b0;
            m_pend  = 1'b0;
        end else if (hd) begin
            if (m_push) mq.push_back({a, i});
        end else if (mq.size() > 0) begin
            {m_addr, m_inst} = mq.pop_front();
            m_valid = 1'b1;
            if (m_push) mq.push_back({a, i});
        end else if (m_push) begin
            m_addr  = a;
            m_inst  = i;
            m_valid = 1'b1;
        end else begin
            m_inst  = NOP;
            m_valid = 1'b0;
        end
        @(posedge clk_i);
        #1;
        cmp_all("cyc");
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        model_reset();
        cmp_all("rst");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        logic [31:0] hz [4];
        logic [31:0] abc [3];
        int          k;

        valid_i     = 1'b0;
        inst_addr_i = '0;
        inst_i      = '0;
        hd_i        = 1'b0;
        memstall_i  = 1'b0;
        flush_i     = 1'b0;
        rst_i       = 1'b1;
        #2;
        model_reset();
        cmp_all("reset");
        chk("reset_ready", 64'(ready_o), 64'(1));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Streaming A, B, C with no stalls.
        abc = '{32'h0123_4567, 32'h89AB_CDEF, 32'h2468_ACE0};
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 32'(c * 4), abc[c], 1'b0, 1'b0, 1'b0);
            chk("stream_inst",  64'(inst_o),  64'(abc[c]));
            chk("stream_count", 64'(count_o), 64'(0));
            chk("stream_valid", 64'(valid_o), 64'(1));
        end

        // Hazard fill: fetch only advances when the stage accepted.
        do_reset();
        hz = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
        k  = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(k < 4, 32'(k * 4), hz[k < 4 ? k : 0], (c >= 1 && c <= 3), 1'b0, 1'b0);
            if (m_push) k++;
            if (c == 3) begin
                chk("hz_full_count", 64'(count_o), 64'(2));
                chk("hz_d_held", 64'(k), 64'(3));
            end
            if (c >= 3 && c <= 6) chk("hz_order", 64'(inst_o), 64'(hz[c - 3]));
        end

        // Flush while stalled on a hazard with two queued entries.
        cyc(1'b1, 32'h10, 32'hAAAA_0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h14, 32'hBBBB_0000, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h18, 32'hCCCC_0000, 1'b1, 1'b0, 1'b0);
        chk("fl_pre_count", 64'(count_o), 64'(2));
        cyc(1'b1, 32'h1C, 32'hDDDD_0000, 1'b1, 1'b0, 1'b1);
        chk("fl_count", 64'(count_o), 64'(0));
        chk("fl_inst",  64'(inst_o),  64'(NOP));
        chk("fl_valid", 64'(valid_o), 64'(0));
        chk("fl_op",    64'(op_o),    64'(6'h3F));
        valid_i = 1'b0;
        hd_i    = 1'b0;
        flush_i = 1'b0;
        #1;
        chk("fl_ready", 64'(ready_o), 64'(1));
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("fl_dropped", 64'(valid_o), 64'(0));

        // Flush arriving during a memory stall is held until the stall ends.
        cyc(1'b1, 32'h40, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cyc(1'b1, 32'h44, 32'h6666_BBBB, 1'b0, 1'b1, (c == 1));
            chk("ms_frozen", 64'(inst_o), 64'(32'h5555_AAAA));
        end
        cyc(1'b1, 32'h48, 32'h7777_CCCC, 1'b0, 1'b0, 1'b0);
        chk("dfl_inst",  64'(inst_o),  64'(NOP));
        chk("dfl_valid", 64'(valid_o), 64'(0));
        chk("dfl_count", 64'(count_o), 64'(0));

        // Empty advance inserts a bubble and keeps the address.
        cyc(1'b1, 32'h80, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("bub_valid", 64'(valid_o),     64'(0));
        chk("bub_inst",  64'(inst_o),      64'(NOP));
        chk("bub_addr",  64'(inst_addr_o), 64'(32'h80));

        // Asynchronous reset between edges with a full queue.
        cyc(1'b1, 32'h90, 32'h1234_0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h94, 32'h1234_0001, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h98, 32'h1234_0002, 1'b1, 1'b0, 1'b0);
        chk("ar_pre_count", 64'(count_o), 64'(2));
        #3;
        rst_i = 1'b1;
        #1;
        chk("ar_inst",  64'(inst_o),      64'(NOP));
        chk("ar_addr",  64'(inst_addr_o), 64'(0));
        chk("ar_valid", 64'(valid_o),     64'(0));
        chk("ar_count", 64'(count_o),     64'(0));
        chk("ar_ready", 64'(ready_o),     64'(1));
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            cyc(($urandom_range(9) < 7), $urandom, $urandom, ($urandom_range(9) < 3),
                ($urandom_range(19) < 3), ($urandom_range(19) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised next-generation IF/ID pipeline stage.
- A decode slot register feeds the ID stage and exposes decoded instruction fields.
- A DEPTH-entry instruction queue sits in front of the slot, so fetch keeps running during decode hazard stalls.
- Adds valid tracking, ready back-pressure to fetch, and a sticky flush that is deferred across memory stalls.

Parameters:
- ADDR_W, 32, width of instruction address.
- INST_W, 32, instruction width; field extraction requires INST_W=32.
- DEPTH, 2, queue entries (>=1).
- NOP_INST, 32'hFC000000, bubble instruction loaded on reset, flush or empty advance.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- inst_addr_i  in  ADDR_W  fetched instruction address.
- inst_i  in  INST_W  fetched instruction.
- valid_i  in  1  fetch presents an instruction this cycle.
- ready_o  out  1  stage accepts the fetch this cycle; equals !memstall_i & (count_o<DEPTH).
- hd_i  in  1  hazard-detect stall: decode slot holds.
- memstall_i  in  1  memory stall: whole block freezes.
- flush_i  in  1  discard wrong-path instructions.
- inst_o  out  INST_W  decode slot instruction.
- inst_addr_o  out  ADDR_W  decode slot address.
- valid_o  out  1  decode slot holds a real instruction.
- op_o  out  6  inst_o[31:26].
- rs_o  out  5  inst_o[25:21].
- rt_o  out  5  inst_o[20:16].
- rd_o  out  5  inst_o[15:11].
- imm_o  out  16  inst_o[15:0].
- jaddr_o  out  26  inst_o[25:0].
- count_o  out  $clog2(DEPTH+1)  queue occupancy.

Behaviour:
- Reset (async, immediate):
  - inst_o=NOP_INST, inst_addr_o=0, valid_o=0.
  - Queue empty, count_o=0, pointers=0, flush_pend=0.
  - ready_o then follows its combinational equation.
- Definitions:
  - push = valid_i & ready_o.
  - eff_flush = flush_i | flush_pend.
  - adv = !memstall_i & !hd_i.
- Priority per cycle: memstall_i > eff_flush > hd_i > normal.
- memstall_i=1:
  - All state holds; ready_o=0, so nothing is accepted.
  - If flush_i=1, set flush_pend=1. It clears only when the flush is applied.
- eff_flush with memstall_i=0:
  - Queue cleared, count_o=0.
  - Slot: inst_o<=NOP_INST, valid_o<=0, inst_addr_o holds.
  - Any push this cycle is consumed and dropped, including during hd_i.
  - flush_pend<=0.
- hd_i=1 (no flush, no memstall):
  - Slot holds.
  - A push is written at the queue tail; count+1.
- adv (no flush), four cases:
  - Queue non-empty, no push: slot loads queue head, valid_o<=1, count-1.
  - Queue non-empty with push: pop head into slot, write input at tail, count unchanged. Ordering is strictly FIFO.
  - Queue empty with push: bypass the input straight into the slot, valid_o<=1 (1-cycle latency, same as a plain pipeline register).
  - Queue empty, no push: slot<=NOP_INST, valid_o<=0, inst_addr_o holds.
- Full boundary:
  - At count_o==DEPTH, ready_o=0 and no push occurs.
  - A pop in the same cycle does not reopen ready_o until the next cycle (ready_o is derived from the registered count).
- Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Field outputs are combinational slices of the slot register, with no extra latency.
- Reset asserted mid-stall or mid-flush overrides everything, including flush_pend.

Test Plan:
- Streaming: reset, then valid_i=1 with addrs 0,4,8 and insts A,B,C, no stalls -> inst_o=A/B/C on cycles 1/2/3, valid_o=1, count_o=0 throughout, ready_o=1.
- Hazard fill: stream A..D; assert hd_i for 3 cycles after A enters the slot, DEPTH=2 -> slot holds A; B,C are queued; count_o reaches 2; ready_o=0 and D is held by fetch. After hd_i drops, slot shows B, C, D in order with no loss or duplication.
- Flush: with 2 queued entries and hd_i=1, pulse flush_i with valid_i=1 -> next cycle count_o=0, inst_o=32'hFC000000, valid_o=0, op_o=6'h3F, ready_o=1, and the input is dropped.
- Deferred flush: memstall_i=1 for 4 cycles with a flush_i pulse in cycle 2 -> all outputs frozen; on the first cycle with memstall_i=0 the flush is applied (inst_o=NOP, valid_o=0, count_o=0).
- Empty advance: valid_i=0 with no stalls -> bubble inserted (valid_o=0, inst_o=NOP), inst_addr_o unchanged.
- Async reset: assert rst_i between clock edges while count_o=2 -> outputs return to reset values immediately, before the next edge.
